// File: rtl/io_input_reg.sv
// io_input_reg: IO-space input ports with 2-flop synchronizers, sticky change flags and
// an optional per-port debounce filter enabled by defining IO_IN_DEBOUNCE_EN.
module io_input_reg #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        io_clk,
    input  logic        clr,
    input  logic [31:0] addr,
    input  logic        read_io_enable,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] dataout,
    output logic        io_chg
);
    logic [31:0] pin    [2];
    logic [31:0] sync1  [2];
    logic [31:0] sync2  [2];
    logic [31:0] stable [2];
    logic [1:0]  chg, acc, rclr;
    logic [5:0]  sel;
    logic        unused_bits;

    assign pin[0] = in_port0;
    assign pin[1] = in_port1;
    assign sel = addr[7:2];
    assign rclr = {read_io_enable && sel == 6'b110001, read_io_enable && sel == 6'b110000};
    assign unused_bits = ^{addr[31:8], addr[1:0]} ^ (DEBOUNCE_CYCLES == 0);

`ifdef IO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [31:0]   cand [2];
    logic [CW-1:0] cnt  [2];

    // acceptance happens only after the candidate has held for DEBOUNCE_CYCLES cycles
    always_comb begin
        acc = '0;
        for (int i = 0; i < 2; i++)
            acc[i] = sync2[i] == cand[i] && cand[i] != stable[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
    end

    always_ff @(posedge io_clk) begin
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                cand[i]   <= '0;
                cnt[i]    <= '0;
                stable[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != cand[i]) begin
                    cand[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else if (cand[i] != stable[i]) begin
                    if (acc[i]) begin
                        stable[i] <= cand[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
`else
    always_comb begin
        acc = '0;
        for (int i = 0; i < 2; i++)
            acc[i] = sync2[i] != stable[i];
    end

    always_ff @(posedge io_clk) begin
        for (int i = 0; i < 2; i++)
            stable[i] <= clr ? '0 : sync2[i];
    end
`endif

    // a flag being set wins over a simultaneous read-clear
    always_ff @(posedge io_clk) begin
        if (clr) begin
            chg <= '0;
            for (int i = 0; i < 2; i++) begin
                sync1[i] <= '0;
                sync2[i] <= '0;
            end
        end else begin
            chg <= acc | (chg & ~rclr);
            for (int i = 0; i < 2; i++) begin
                sync1[i] <= pin[i];
                sync2[i] <= sync1[i];
            end
        end
    end

    always_comb begin
        dataout = sel == 6'b110001 ? stable[1] : sel == 6'b110010 ? {30'b0, chg} : stable[0];
        io_chg  = |chg;
    end
endmodule
